// File: rtl/systolic_skew_feeder_if.sv
// Handshake and edge-bus bundle for systolic_skew_feeder.
// bubble_cnt exists only when FEEDER_BUBBLE_CNT_EN is defined.
interface systolic_skew_feeder_if #(
    parameter int N  = 4,
    parameter int DW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic [N*DW-1:0] a_vec;
    logic [N*DW-1:0] b_vec;
    logic [N*DW-1:0] a_edge;
    logic [N*DW-1:0] b_edge;
    logic [N-1:0]    edge_vld;
    logic          busy;
    logic          done;
`ifdef FEEDER_BUBBLE_CNT_EN
    logic [15:0]   bubble_cnt;
`endif

    modport master (
        output in_valid,
        output in_last,
        output a_vec,
        output b_vec,
        input  in_ready,
        input  a_edge,
        input  b_edge,
        input  edge_vld,
        input  busy,
        input  done
`ifdef FEEDER_BUBBLE_CNT_EN
        , input bubble_cnt
`endif
    );

    modport slave (
        input  in_valid,
        input  in_last,
        input  a_vec,
        input  b_vec,
        output in_ready,
        output a_edge,
        output b_edge,
        output edge_vld,
        output busy,
        output done
`ifdef FEEDER_BUBBLE_CNT_EN
        , output bubble_cnt
`endif
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Triangular-skew operand feeder for an NxN systolic MAC array.
// Optional stall counter enabled by FEEDER_BUBBLE_CNT_EN.
module systolic_skew_feeder #(
    parameter int N  = 4,
    parameter int DW = 16,
    parameter int CW = 2 + $clog2(2 * N)
) (
    input  logic clk,
    input  logic rst_n,
    systolic_skew_feeder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH,
        DONE
    } state_t;

    localparam logic [CW-1:0] FLUSH_LAST = CW'(2 * N - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_flush_cnt;
    logic [CW-1:0] w_flush_cnt_nxt;
    logic          r_in_ready;
    logic          w_accept;

    assign w_accept = bus.in_valid & r_in_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = bus.in_last ? FLUSH : STREAM;
                end
            end
            STREAM: begin
                if (w_accept && bus.in_last) begin
                    w_state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (r_flush_cnt == FLUSH_LAST) begin
                    w_state_nxt = DONE;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt + 1'b1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // in_ready is registered from the next state so it stays low throughout reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_flush_cnt <= '0;
            r_in_ready  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_in_ready  <= (w_state_nxt == IDLE) || (w_state_nxt == STREAM);
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.busy     = (r_state != IDLE);
    assign bus.done     = (r_state == DONE);

    for (genvar i = 0; i < N; i++) begin : g_lane
        localparam int unsigned D = i;

        logic [DW-1:0] r_a [0:i];
        logic [DW-1:0] r_b [0:i];
        logic          r_v [0:i];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned k = 0; k <= D; k++) begin
                    r_a[k] <= '0;
                    r_b[k] <= '0;
                    r_v[k] <= 1'b0;
                end
            end else begin
                r_a[0] <= w_accept ? bus.a_vec[i*DW +: DW] : '0;
                r_b[0] <= w_accept ? bus.b_vec[i*DW +: DW] : '0;
                r_v[0] <= w_accept;
                for (int unsigned k = 1; k <= D; k++) begin
                    r_a[k] <= r_a[k-1];
                    r_b[k] <= r_b[k-1];
                    r_v[k] <= r_v[k-1];
                end
            end
        end

        assign bus.a_edge[i*DW +: DW] = r_a[i];
        assign bus.b_edge[i*DW +: DW] = r_b[i];
        assign bus.edge_vld[i]        = r_v[i];
    end

`ifdef FEEDER_BUBBLE_CNT_EN
    logic [15:0] r_bubble_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
        end else if (r_state == IDLE && w_accept) begin
            r_bubble_cnt <= '0;
        end else if (r_state == STREAM && !bus.in_valid && r_bubble_cnt != '1) begin
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign bus.bubble_cnt = r_bubble_cnt;
`endif

endmodule
